toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive end of the T-flip-flop toggle-signalling scheme used across the timer design. A TFF "encodes" each event as one toggle of its q output; this block "decodes" that toggle stream.
- It takes the toggling level from another clock domain or from asynchronous logic, synchronises it, and turns every toggle into one event.
- Events are buffered as a pending count and offered on a valid/ready interface. Downstream counters and timers therefore never lose a toggle that arrives while they are stalled.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on t_in (min 2).
- PEND_W, 4, width of pending-event counter; capacity is 2^PEND_W-1 events.
- CNT_W, 16, width of free-running accepted-event total.
- FILT_CYC, 3, stability cycles for the optional glitch filter (min 1).

Ports:
- clk  in  1  rising-edge clock.
- clr_b  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- t_in  in  1  toggle level from a TFF q; asynchronous to clk.
- en  in  1  decode enable; toggles seen while en=0 are tracked but not counted.
- evt_valid  out  1  at least one pending event.
- evt_ready  in  1  consumer accepts one event when evt_valid&&evt_ready.
- pend_cnt  out  PEND_W  current pending events.
- evt_total  out  CNT_W  accepted events since reset, wraps modulo 2^CNT_W.
- ovf  out  1  sticky: a toggle was dropped because the pending counter was full.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (clr_b=0, async): sync chain=0, t_ref=0, state=INIT, init counter=0, pend_cnt=0, evt_valid=0, evt_total=0, ovf=0.
- FSM states:
  - INIT: counts SYNC_STAGES cycles after reset release. On the last INIT cycle it loads t_ref with the synchronised value, generates no event, then goes to RUN. A t_in held at 1 through reset therefore yields no spurious event.
  - RUN: steady state. The only exit is clr_b=0, which returns to INIT from any state, mid-operation included.
- Toggle detect in RUN: tgl = t_sync ^ t_ref. On tgl, t_ref <= t_sync in the same cycle, whatever en is.
- A toggle is accepted when en=1 and pend_cnt != max, or when en=1, pend_cnt = max and a pop happens in the same cycle.
- Pending counter update:
  - accept only: +1.
  - pop only: -1.
  - accept and pop together: unchanged.
  - pop with pend_cnt=0 cannot occur, because evt_valid=0.
- Full condition: pend_cnt = 2^PEND_W-1, a toggle arrives and there is no pop. The toggle is dropped, pend_cnt holds, ovf <= 1 and evt_total is not incremented.
- evt_total increments by 1 per accepted toggle and wraps to 0 from all-ones.
- ovf clear: ovf_clr=1 clears ovf. If overflow and ovf_clr occur in the same cycle, set wins (ovf=1).
- evt_valid is registered: evt_valid = (pend_cnt != 0), derived from the registered count. No combinational path from evt_ready to evt_valid.
- Latency (filter disabled): a t_in edge sampled at clock edge k gives tgl at edge k+SYNC_STAGES, with pend_cnt/evt_valid updated at that same edge. evt_valid is therefore visible SYNC_STAGES+1 rising edges after t_in changes (worst case, given sampling-phase uncertainty).
- Toggle rate limit: at most one toggle per SYNC_STAGES clk cycles. Two toggles inside one sample window cancel (no event); this is a documented source constraint, not an error.

Optional Feature:
- Macro: TOGGLE_DECODER_GLITCH_FILTER_EN.
- Defined:
  - A candidate register follows t_sync. A stability counter counts consecutive cycles with t_sync equal to the candidate.
  - t_filt updates only after FILT_CYC equal cycles. Toggle detect uses t_filt instead of t_sync, and INIT also loads t_ref from t_filt.
  - Pulses on t_in shorter than FILT_CYC cycles produce no event.
  - Latency grows by FILT_CYC cycles.
- Undefined: no filter logic; t_sync feeds detection directly.

Decomposition:
- Package toggle_decoder_pkg holds:
  - the state enum typedef (INIT, RUN).
  - the localparam minimum SYNC_STAGES of 2.
  - a function returning the pending-counter max for a given width.
- One natural sub-module: bit_synchronizer (parameterised SYNC_STAGES flop chain, async active-low reset to 0). It is reusable by other timer blocks.

Test Plan:
- Reset with t_in=1 held, release, no toggles for 10 cycles -> evt_valid=0, pend_cnt=0, evt_total=0 throughout.
- t_in toggles every 8 cycles ×5, evt_ready=1 -> exactly 5 single-cycle evt_valid pulses, each 3 edges after the t_in change (SYNC_STAGES=2), evt_total=5.
- evt_ready=0, 17 toggles spaced 4 cycles (PEND_W=4) -> pend_cnt saturates at 15, ovf=1 after the 16th toggle, evt_total=15. Then evt_ready=1 -> 15 pops and evt_valid drops.
- pend_cnt=15 with a toggle and a pop in the same cycle -> pend_cnt stays 15, ovf stays 0, evt_total +1. Then ovf set together with ovf_clr -> ovf=1.
- en=0 during 3 toggles, then en=1 with no toggle -> no events, pend_cnt=0; the next toggle gives exactly 1 event.
- clr_b asserted with pend_cnt=6 mid-stream -> all outputs 0 immediately (async). After release the INIT sequence repeats and no spurious event occurs.
- With TOGGLE_DECODER_GLITCH_FILTER_EN and FILT_CYC=3: a 2-cycle t_in pulse gives no event, and a 5-cycle level change gives 1 event.

Source files
------------

// File: rtl/toggle_decoder_pkg.sv
// Shared types and helpers for the toggle event decoder and its synchroniser.
package toggle_decoder_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // Largest value a pending counter of the given width can hold.
  function automatic int unsigned pend_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit flop-chain synchroniser, async active-low reset to 0.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes a TFF toggle stream into buffered valid/ready events.
// Optional glitch filter on the synchronised level: TOGGLE_DECODER_GLITCH_FILTER_EN.
module toggle_event_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 16,
  parameter int FILT_CYC    = 3
) (
  input  logic              clk,
  input  logic              clr_b,
  input  logic              t_in,
  input  logic              en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  evt_total,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int INIT_W = $clog2(SYNC_N + FILT_CYC + 2);
  localparam logic [PEND_W-1:0] PMAX = PEND_W'(pend_max(PEND_W));

  logic w_t_sync;
  logic w_t_det;

  bit_synchronizer #(.STAGES(SYNC_N)) u_sync (
    .clk   (clk),
    .rst_n (clr_b),
    .d     (t_in),
    .q     (w_t_sync)
  );

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_CYC + 1);
  // INIT must outlast the filter too, so a level held through reset is absorbed.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_N + FILT_CYC);

  logic            r_cand;
  logic [FC_W-1:0] r_stab;
  logic            r_filt;
  logic [FC_W-1:0] w_len;

  // w_len = run length of the current t_sync value including this cycle, saturated.
  always_comb begin
    w_len = FC_W'(1);
    if (w_t_sync == r_cand)
      w_len = (r_stab == FC_W'(FILT_CYC)) ? r_stab : r_stab + FC_W'(1);
  end

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      r_cand <= 1'b0;
      r_stab <= '0;
      r_filt <= 1'b0;
    end else begin
      r_cand <= w_t_sync;
      r_stab <= w_len;
      if (w_len == FC_W'(FILT_CYC)) r_filt <= w_t_sync;
    end
  end

  assign w_t_det = r_filt;
`else
  // t_sync is only valid SYNC_N edges after release; load it on the edge after.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_N);

  assign w_t_det = w_t_sync;
`endif

  state_t            r_state, w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt;
  logic              r_t_ref;
  logic              w_init_done;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_done = 1'b0;
    case (r_state)
      ST_INIT: if (r_init_cnt == INIT_LAST) begin
        w_init_done = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  logic w_tgl, w_pop, w_accept, w_drop;

  assign w_tgl    = (r_state == ST_RUN) && (w_t_det ^ r_t_ref);
  assign w_pop    = evt_valid && evt_ready;
  assign w_accept = w_tgl && en && ((pend_cnt != PMAX) || w_pop);
  assign w_drop   = w_tgl && en && (pend_cnt == PMAX) && !w_pop;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      r_init_cnt <= '0;
      r_t_ref    <= 1'b0;
    end else begin
      if (r_state == ST_INIT && !w_init_done) r_init_cnt <= r_init_cnt + INIT_W'(1);
      // Reference tracks every toggle so disabled periods leave no backlog.
      if (w_init_done || w_tgl) r_t_ref <= w_t_det;
    end
  end

  logic [PEND_W-1:0] w_pend_nxt;

  always_comb begin
    w_pend_nxt = pend_cnt;
    case ({w_accept, w_pop})
      2'b10:   w_pend_nxt = pend_cnt + PEND_W'(1);
      2'b01:   w_pend_nxt = pend_cnt - PEND_W'(1);
      default: w_pend_nxt = pend_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      pend_cnt  <= '0;
      evt_valid <= 1'b0;
      evt_total <= '0;
      ovf       <= 1'b0;
    end else begin
      pend_cnt  <= w_pend_nxt;
      evt_valid <= (w_pend_nxt != '0);
      if (w_accept) evt_total <= evt_total + CNT_W'(1);
      if (w_drop)       ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder (default parameters).
module tb_toggle_event_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int PEND_W      = 4;
  localparam int CNT_W       = 16;
  localparam int FILT_CYC    = 3;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILT_CYC;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int SP = LAT + 1;

  logic clk = 1'b0;
  logic clr_b, t_in, en, evt_ready, ovf_clr;
  logic evt_valid, ovf;
  logic [PEND_W-1:0] pend_cnt;
  logic [CNT_W-1:0]  evt_total;

  int n_chk = 0;
  int n_bad = 0;

  toggle_event_decoder #(
    .SYNC_STAGES(SYNC_STAGES), .PEND_W(PEND_W), .CNT_W(CNT_W), .FILT_CYC(FILT_CYC)
  ) dut (
    .clk(clk), .clr_b(clr_b), .t_in(t_in), .en(en),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pend_cnt(pend_cnt), .evt_total(evt_total),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int pulses, at;
    clr_b = 1'b0; t_in = 1'b1; en = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;

    // Reset with t_in held high; no spurious event after release.
    #2;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_pend",  32'(pend_cnt), 0);
    chk("rst_total", 32'(evt_total), 0);
    chk("rst_ovf",   32'(ovf), 0);
    tick(2);
    clr_b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("init_valid", 32'(evt_valid), 0);
      chk("init_pend",  32'(pend_cnt), 0);
    end
    chk("init_total", 32'(evt_total), 0);

    // Five toggles, consumer always ready: one pulse each, LAT edges late.
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t_in = ~t_in;
      pulses = 0; at = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (evt_valid) begin pulses++; at = c; end
      end
      chk("pulse_cnt", 32'(pulses), 1);
      chk("pulse_lat", 32'(at), 32'(LAT));
    end
    chk("total_5", 32'(evt_total), 5);

    // Stalled consumer: saturate at 15, overflow on the 16th toggle.
    evt_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      t_in = ~t_in;
      tick(SP);
      chk("sat_pend", 32'(pend_cnt), (i > 15) ? 15 : i);
      chk("sat_ovf",  32'(ovf), (i >= 16) ? 1 : 0);
    end
    chk("sat_total", 32'(evt_total), 20);
    chk("sat_valid", 32'(evt_valid), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // Full counter, toggle and pop on the same edge: accepted, no overflow.
    t_in = ~t_in;
    tick(LAT - 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("fullpop_pend",  32'(pend_cnt), 15);
    chk("fullpop_ovf",   32'(ovf), 0);
    chk("fullpop_total", 32'(evt_total), 21);

    // Overflow and clear on the same edge: set wins.
    t_in = ~t_in;
    tick(LAT - 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("setwin_ovf",   32'(ovf), 1);
    chk("setwin_total", 32'(evt_total), 21);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 0);

    // Drain all 15.
    evt_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("drain_pend", 32'(pend_cnt), 32'(15 - i));
    end
    chk("drain_valid", 32'(evt_valid), 0);
    evt_ready = 1'b0;

    // Disabled toggles are tracked but never become events.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_in = ~t_in;
      tick(SP);
    end
    en = 1'b1;
    tick(SP);
    chk("en0_pend",  32'(pend_cnt), 0);
    chk("en0_valid", 32'(evt_valid), 0);
    chk("en0_total", 32'(evt_total), 21);
    t_in = ~t_in;
    tick(LAT);
    chk("en1_valid", 32'(evt_valid), 1);
    chk("en1_pend",  32'(pend_cnt), 1);
    chk("en1_total", 32'(evt_total), 22);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("en1_pop", 32'(pend_cnt), 0);

    // Async reset mid-stream with six pending.
    for (int i = 0; i < 6; i++) begin
      t_in = ~t_in;
      tick(SP);
    end
    chk("mid_pend", 32'(pend_cnt), 6);
    #2 clr_b = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 0);
    chk("arst_pend",  32'(pend_cnt), 0);
    chk("arst_total", 32'(evt_total), 0);
    chk("arst_ovf",   32'(ovf), 0);
    t_in = 1'b1;
    tick(2);
    clr_b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rinit_valid", 32'(evt_valid), 0);
    end
    chk("rinit_total", 32'(evt_total), 0);
    t_in = 1'b0;
    tick(LAT);
    chk("rerun_valid", 32'(evt_valid), 1);
    chk("rerun_total", 32'(evt_total), 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("rerun_pop", 32'(pend_cnt), 0);

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
    // Short pulse is filtered; a sustained level change is one event.
    t_in = 1'b1; tick(2); t_in = 1'b0;
    tick(12);
    chk("glitch_pend",  32'(pend_cnt), 0);
    chk("glitch_total", 32'(evt_total), 1);
    t_in = 1'b1;
    tick(12);
    chk("level_pend",  32'(pend_cnt), 1);
    chk("level_total", 32'(evt_total), 2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
